// File: rtl/cntr_pkg.sv
// Shared types for the counter command sequencer: opcodes, the command word
// and the issue FSM states.
package cntr_pkg;

  localparam int CNTR_W = 8;

  typedef enum logic [1:0] {
    OP_NOP       = 2'b00,
    OP_INC       = 2'b01,
    OP_LD        = 2'b10,
    OP_INC_BURST = 2'b11
  } cmd_op_t;

  typedef struct packed {
    cmd_op_t            op;
    logic [CNTR_W-1:0]  data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } seq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two). An overflowing push or an
// underflowing pop is ignored.
module cmd_fifo
  import cntr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CMD_W-1:0]  wdata,
  output logic [CMD_W-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cntr_cmd_seq.sv
// Command sequencer: queues NOP/INC/LD/INC_BURST commands and issues ld/inc
// strobes to a downstream counter. Define CNTR_CMD_BURST_EN for burst support.
module cntr_cmd_seq
  import cntr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CNTR_W-1:0]  cmd_data,
  output logic               ld,
  output logic               inc,
  output logic [CNTR_W-1:0]  data_in,
  output logic               busy,
  output logic [LW-1:0]      fifo_level
);

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] head_raw;
  cmd_t             head;
  cmd_t             wr_cmd;

  assign cmd_ready = !full && rst;
  assign push      = cmd_valid && cmd_ready;
  assign wr_cmd    = '{op: cmd_op_t'(cmd_op), data: cmd_data};
  assign head      = head_raw;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

`ifdef CNTR_CMD_BURST_EN
  seq_state_t        state;
  logic [CNTR_W-1:0] burst_cnt;

  assign pop  = (state == S_IDLE) && !empty;
  assign busy = !empty || (state == S_BURST);
`else
  assign pop  = !empty;
  assign busy = !empty;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      ld      <= 1'b0;
      inc     <= 1'b0;
      data_in <= '0;
`ifdef CNTR_CMD_BURST_EN
      state     <= S_IDLE;
      burst_cnt <= '0;
`endif
    end else begin
      ld  <= 1'b0;
      inc <= 1'b0;
`ifdef CNTR_CMD_BURST_EN
      // burst_cnt holds pulses still owed after the current one.
      if (state == S_BURST) begin
        inc       <= 1'b1;
        burst_cnt <= burst_cnt - 1'b1;
        if (burst_cnt == CNTR_W'(1)) state <= S_IDLE;
      end else
`endif
      if (pop) begin
        case (head.op)
          OP_INC: inc <= 1'b1;
          OP_LD: begin
            ld      <= 1'b1;
            data_in <= head.data;
          end
          OP_INC_BURST: begin
`ifdef CNTR_CMD_BURST_EN
            if (head.data != '0) begin
              inc       <= 1'b1;
              burst_cnt <= head.data - 1'b1;
              if (head.data != CNTR_W'(1)) state <= S_BURST;
            end
`else
            inc <= 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
